hazard_forward_unit: RTL and testbench



---
 rtl/pcpu_ctrl_pkg.sv | 25 ++
 rtl/md_scoreboard.sv | 61 ++++++
 rtl/hazard_forward_unit.sv | 91 +++++++++
 tb/tb_hazard_forward_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_ctrl_pkg.sv
// Shared control-path definitions: forward-select codes, mul/div scoreboard
// states and the operand-forward priority encoder.
package pcpu_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_MD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    // The mul/div result is the youngest producer, so it wins over MEM, then WB.
    function automatic logic [1:0] fwd_pick(input logic md_hit, input logic mem_hit,
                                            input logic wb_hit);
        if (md_hit)       return FWD_MD;
        else if (mem_hit) return FWD_MEM;
        else if (wb_hit)  return FWD_WB;
        else              return FWD_RF;
    endfunction

endpackage

// File: rtl/md_scoreboard.sv
// Tracks the single multi-cycle mul/div unit: issue, countdown, one-cycle
// completion window and the sticky overrun flag.
module md_scoreboard
    import pcpu_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 8,
    parameter int CNT_W  = $clog2(MD_LAT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              md_start,
    input  logic [REG_AW-1:0] md_rw,
    output md_state_t         state,
    output logic [REG_AW-1:0] md_rw_q,
    output logic              md_overrun
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2);
    // With the minimum latency the result is due the very next cycle.
    localparam md_state_t        ST_ISSUE = (MD_LAT == 2) ? DONE : BUSY;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            md_rw_q    <= '0;
            md_overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start) begin
                        state   <= ST_ISSUE;
                        cnt     <= CNT_LOAD;
                        md_rw_q <= md_rw;
                    end
                end
                BUSY: begin
                    if (md_start) md_overrun <= 1'b1;
                    cnt <= cnt - 1'b1;
                    // Leaves BUSY as the count reaches 1, so DONE lands MD_LAT-1 cycles after issue.
                    if (cnt == CNT_LAST) state <= DONE;
                end
                DONE: begin
                    if (md_start) begin
                        state   <= ST_ISSUE;
                        cnt     <= CNT_LOAD;
                        md_rw_q <= md_rw;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX operand forwarding, load-use and mul/div hazard detection; owns stall,
// flush and mul/div completion timing for IF/ID/EX.
module hazard_forward_unit
    import pcpu_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 8,
    parameter int CNT_W  = $clog2(MD_LAT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_ra,
    input  logic [REG_AW-1:0] id_rb,
    input  logic              id_ra_used,
    input  logic              id_rb_used,
    input  logic [REG_AW-1:0] id_rw,
    input  logic              id_regwr,
    input  logic [REG_AW-1:0] ex_ra,
    input  logic [REG_AW-1:0] ex_rb,
    input  logic [REG_AW-1:0] ex_rw,
    input  logic              ex_regwr,
    input  logic              ex_memrd,
    input  logic [REG_AW-1:0] mem_rw,
    input  logic              mem_regwr,
    input  logic [REG_AW-1:0] wr_rw,
    input  logic              wr_regwr,
    input  logic              md_start,
    input  logic [REG_AW-1:0] md_rw,
    output logic [1:0]        forwardA,
    output logic [1:0]        forwardB,
    output logic              stall,
    output logic              flush_ex,
    output logic              md_busy,
    output logic              md_done,
    output logic              md_overrun
);

    md_state_t         state;
    logic [REG_AW-1:0] md_rw_q;
    logic              md_ovr_q;

    md_scoreboard #(
        .REG_AW (REG_AW),
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) u_md_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .md_start   (md_start),
        .md_rw      (md_rw),
        .state      (state),
        .md_rw_q    (md_rw_q),
        .md_overrun (md_ovr_q)
    );

    logic md_live, md_open, mem_live, wb_live;
    logic load_use, md_hazard, stall_int;
    logic [1:0] fwd_a, fwd_b;

    // Register 0 never produces a hazard or a forward.
    assign md_live  = (md_rw_q != '0);
    assign md_open  = (state == DONE) && md_live;
    assign mem_live = mem_regwr && (mem_rw != '0);
    assign wb_live  = wr_regwr && (wr_rw != '0);

    assign fwd_a = fwd_pick(md_open && (md_rw_q == ex_ra),
                            mem_live && (mem_rw == ex_ra),
                            wb_live && (wr_rw == ex_ra));
    assign fwd_b = fwd_pick(md_open && (md_rw_q == ex_rb),
                            mem_live && (mem_rw == ex_rb),
                            wb_live && (wr_rw == ex_rb));

    assign load_use  = ex_memrd && ex_regwr && (ex_rw != '0) &&
                       ((id_ra_used && (id_ra == ex_rw)) || (id_rb_used && (id_rb == ex_rw)));
    assign md_hazard = (state == BUSY) && md_live &&
                       ((id_ra_used && (id_ra == md_rw_q)) ||
                        (id_rb_used && (id_rb == md_rw_q)) ||
                        (id_regwr   && (id_rw == md_rw_q)));
    // DONE always stalls: the mul/div result owns the WB write port that cycle.
    assign stall_int = load_use || md_hazard || (state == DONE);

    // Outputs are held at zero for the whole reset, whatever the pipeline inputs say.
    assign forwardA   = rst_n ? fwd_a : FWD_RF;
    assign forwardB   = rst_n ? fwd_b : FWD_RF;
    assign stall      = rst_n && stall_int;
    assign flush_ex   = rst_n && stall_int;
    assign md_busy    = rst_n && ((state == BUSY) || (state == DONE));
    assign md_done    = rst_n && (state == DONE);
    assign md_overrun = rst_n && md_ovr_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomized and directed bench for hazard_forward_unit against a cycle-count
// reference model of the mul/div unit.
module tb_hazard_forward_unit;

    localparam int REG_AW = 5;
    localparam int MD_LAT = 8;

    logic              clk, rst_n;
    logic [REG_AW-1:0] id_ra, id_rb, id_rw, ex_ra, ex_rb, ex_rw, mem_rw, wr_rw, md_rw;
    logic              id_ra_used, id_rb_used, id_regwr, ex_regwr, ex_memrd;
    logic              mem_regwr, wr_regwr, md_start;
    logic [1:0]        forwardA, forwardB;
    logic              stall, flush_ex, md_busy, md_done, md_overrun;

    hazard_forward_unit #(.REG_AW(REG_AW), .MD_LAT(MD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_ra(id_ra), .id_rb(id_rb), .id_ra_used(id_ra_used), .id_rb_used(id_rb_used),
        .id_rw(id_rw), .id_regwr(id_regwr),
        .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_rw(ex_rw), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd),
        .mem_rw(mem_rw), .mem_regwr(mem_regwr), .wr_rw(wr_rw), .wr_regwr(wr_regwr),
        .md_start(md_start), .md_rw(md_rw),
        .forwardA(forwardA), .forwardB(forwardB), .stall(stall), .flush_ex(flush_ex),
        .md_busy(md_busy), .md_done(md_done), .md_overrun(md_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: an accepted op issued in cycle c completes in cycle c+MD_LAT-1.
    int                cyc = 0;
    bit                m_act = 0;
    int                m_done_at = 0;
    logic [REG_AW-1:0] m_rw = '0;
    bit                m_ovr = 0;

    function automatic logic [1:0] fwd_exp(input logic [REG_AW-1:0] src, input bit dn);
        if (dn && m_rw != 0 && m_rw == src)       return 2'b11;
        if (mem_regwr && mem_rw != 0 && mem_rw == src) return 2'b10;
        if (wr_regwr && wr_rw != 0 && wr_rw == src)    return 2'b01;
        return 2'b00;
    endfunction

    // Check all outputs against the model for the current cycle, then advance one clock.
    task automatic tick();
        bit dn, bz, lu, mh, st;
        logic [1:0] fa, fb;
        #1;
        if (!rst_n) begin m_act = 0; m_ovr = 0; m_rw = '0; end
        dn = m_act && (cyc == m_done_at);
        bz = m_act && (cyc < m_done_at);
        fa = fwd_exp(ex_ra, dn);
        fb = fwd_exp(ex_rb, dn);
        lu = ex_memrd && ex_regwr && ex_rw != 0 &&
             ((id_ra_used && id_ra == ex_rw) || (id_rb_used && id_rb == ex_rw));
        mh = bz && m_rw != 0 &&
             ((id_ra_used && id_ra == m_rw) || (id_rb_used && id_rb == m_rw) ||
              (id_regwr && id_rw == m_rw));
        st = lu || mh || dn;
        if (!rst_n) begin fa = 0; fb = 0; st = 0; dn = 0; bz = 0; end
        chk("forwardA", 32'(forwardA), 32'(fa));
        chk("forwardB", 32'(forwardB), 32'(fb));
        chk("stall", 32'(stall), 32'(st));
        chk("flush_ex", 32'(flush_ex), 32'(st));
        chk("md_busy", 32'(md_busy), 32'(dn || bz));
        chk("md_done", 32'(md_done), 32'(dn));
        chk("md_overrun", 32'(md_overrun), 32'(m_ovr));
        @(posedge clk);
        if (rst_n) begin
            if (md_start) begin
                if (!bz) begin
                    m_act = 1; m_done_at = cyc + MD_LAT - 1; m_rw = md_rw;
                end else m_ovr = 1;
            end else if (dn) m_act = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clr_in();
        id_ra = 0; id_rb = 0; id_rw = 0; id_ra_used = 0; id_rb_used = 0; id_regwr = 0;
        ex_ra = 0; ex_rb = 0; ex_rw = 0; ex_regwr = 0; ex_memrd = 0;
        mem_rw = 0; mem_regwr = 0; wr_rw = 0; wr_regwr = 0; md_start = 0; md_rw = 0;
    endtask

    // Runs from the first BUSY cycle to the DONE cycle; n ends as the DONE cycle index.
    task automatic run_to_done(input int ovr_at, output int n);
        n = 1;
        while (n < 20) begin
            #1;
            if (md_done) break;
            chk("md_hold_stall", 32'(stall), 32'd1);
            md_start = (n == ovr_at);
            tick();
            n++;
        end
        md_start = 0;
    endtask

    int n;

    initial begin
        rst_n = 0;
        clr_in();
        mem_regwr = 1; mem_rw = 5; ex_ra = 5; ex_rb = 5;
        @(negedge clk);
        #1;
        chk("rst_forwardA", 32'(forwardA), 32'd0);
        chk("rst_busy", 32'(md_busy), 32'd0);
        tick();
        tick();
        rst_n = 1;

        // MEM beats WB; r0 in MEM falls through to WB
        wr_regwr = 1; wr_rw = 5;
        #1;
        chk("fwd_mem_a", 32'(forwardA), 32'd2);
        chk("fwd_mem_b", 32'(forwardB), 32'd2);
        tick();
        mem_rw = 0;
        #1;
        chk("fwd_wb_a", 32'(forwardA), 32'd1);
        chk("fwd_wb_b", 32'(forwardB), 32'd1);
        tick();

        // Load-use on rb
        clr_in();
        ex_memrd = 1; ex_regwr = 1; ex_rw = 3; id_rb = 3; id_rb_used = 1;
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_flush", 32'(flush_ex), 32'd1);
        tick();
        id_rb_used = 0;
        #1;
        chk("lu_unused", 32'(stall), 32'd0);
        tick();

        // Single mul/div to r7 with an ID reader of r7
        clr_in();
        md_start = 1; md_rw = 7;
        tick();
        md_start = 0; id_ra = 7; id_ra_used = 1;
        #1;
        chk("busy_rise", 32'(md_busy), 32'd1);
        run_to_done(0, n);
        chk("md_lat", 32'(n), 32'(MD_LAT - 1));
        ex_ra = 7;
        #1;
        chk("fwd_md", 32'(forwardA), 32'd3);
        // Back-to-back issue in DONE, then an overrun mid-BUSY
        md_start = 1; md_rw = 9;
        tick();
        md_start = 0; id_ra = 9; ex_ra = 0;
        #1;
        chk("b2b_ovr", 32'(md_overrun), 32'd0);
        run_to_done(3, n);
        chk("b2b_lat", 32'(n), 32'(MD_LAT - 1));
        chk("ovr_set", 32'(md_overrun), 32'd1);

        // Reset while BUSY with the count at 4
        md_start = 1; md_rw = 4;
        tick();
        md_start = 0; id_ra = 0; id_ra_used = 0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 0;
        #1;
        chk("abort_busy", 32'(md_busy), 32'd0);
        chk("abort_ovr", 32'(md_overrun), 32'd0);
        tick();
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("abort_no_done", 32'(md_done), 32'd0);
            tick();
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            id_ra = 5'($urandom_range(0, 7)); id_rb = 5'($urandom_range(0, 7));
            id_rw = 5'($urandom_range(0, 7)); ex_ra = 5'($urandom_range(0, 7));
            ex_rb = 5'($urandom_range(0, 7)); ex_rw = 5'($urandom_range(0, 7));
            mem_rw = 5'($urandom_range(0, 7)); wr_rw = 5'($urandom_range(0, 7));
            md_rw = 5'($urandom_range(0, 7));
            id_ra_used = 1'($urandom); id_rb_used = 1'($urandom); id_regwr = 1'($urandom);
            ex_regwr = 1'($urandom); ex_memrd = 1'($urandom);
            mem_regwr = 1'($urandom); wr_regwr = 1'($urandom);
            md_start = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
